// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, latched
// request payload and the effective-address fault mask.
package lsu_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned RAM_AW = 4;
   localparam int unsigned RD_W   = 2;
   localparam int unsigned CNT_W  = 8;

   // Any set bit above the implemented RAM index bits is an out-of-range access.
   localparam logic [ADDR_W-1:0] EA_FAULT_MASK = ~ADDR_W'((1 << RAM_AW) - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX       = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2,
      ST_FLT  = 2'd3
   } lsu_state_t;

   typedef struct packed {
      logic              is_store;
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] wdata;
      logic [RD_W-1:0]   rd;
   } lsu_req_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request, RAM and writeback/fault signals of the load/store unit.
interface load_store_unit_if;
   import lsu_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_is_store;
   logic [ADDR_W-1:0] req_base;
   logic [ADDR_W-1:0] req_offset;
   logic [DATA_W-1:0] req_wdata;
   logic [RD_W-1:0]   req_rd;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              wb_valid;
   logic [RD_W-1:0]   wb_rd;
   logic [DATA_W-1:0] wb_data;

   logic              fault;
   logic [ADDR_W-1:0] fault_addr;
   logic [CNT_W-1:0]  fault_count;

   // Execute stage and RAM side.
   modport master (
      output req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd,
      output mem_rdata,
      input  req_ready, mem_read, mem_write, mem_addr, mem_wdata,
      input  wb_valid, wb_rd, wb_data, fault, fault_addr, fault_count
   );

   // Load/store unit side.
   modport slave (
      input  req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd,
      input  mem_rdata,
      output req_ready, mem_read, mem_write, mem_addr, mem_wdata,
      output wb_valid, wb_rd, wb_data, fault, fault_addr, fault_count
   );

endinterface

// File: rtl/lsu_addr_gen.sv
// Effective address generation: base + offset modulo 2**ADDR_W, with a flag
// for addresses beyond the implemented RAM.
module lsu_addr_gen
   import lsu_pkg::*;
(
   input  logic [ADDR_W-1:0] i_base,
   input  logic [ADDR_W-1:0] i_offset,
   output logic [ADDR_W-1:0] o_ea_c,
   output logic              o_oor_c
);

   assign o_ea_c  = i_base + i_offset;
   assign o_oor_c = |(o_ea_c & EA_FAULT_MASK);

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request at a time, range-checked RAM strobes,
// one-cycle load writeback and fault pulses. All outputs are registered.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   load_store_unit_if.slave  bus
);

   lsu_state_t        r_state,       w_state_nx;
   lsu_req_t          r_req,         w_req_nx;
   logic              r_req_ready,   w_req_ready_nx;
   logic              r_mem_read,    w_mem_read_nx;
   logic              r_mem_write,   w_mem_write_nx;
   logic [ADDR_W-1:0] r_mem_addr,    w_mem_addr_nx;
   logic [DATA_W-1:0] r_mem_wdata,   w_mem_wdata_nx;
   logic              r_wb_valid,    w_wb_valid_nx;
   logic [RD_W-1:0]   r_wb_rd,       w_wb_rd_nx;
   logic [DATA_W-1:0] r_wb_data,     w_wb_data_nx;
   logic              r_fault,       w_fault_nx;
   logic [ADDR_W-1:0] r_fault_addr,  w_fault_addr_nx;
   logic [CNT_W-1:0]  r_fault_count, w_fault_count_nx;

   logic [ADDR_W-1:0] w_ea;
   logic              w_oor;

   lsu_addr_gen u_addr_gen (
      .i_base   (bus.req_base),
      .i_offset (bus.req_offset),
      .o_ea_c   (w_ea),
      .o_oor_c  (w_oor)
   );

   // Next state and next registered outputs; strobes default low, held values default to hold.
   always_comb begin
      w_state_nx       = r_state;
      w_req_nx         = r_req;
      w_mem_read_nx    = 1'b0;
      w_mem_write_nx   = 1'b0;
      w_mem_addr_nx    = '0;
      w_mem_wdata_nx   = '0;
      w_wb_valid_nx    = 1'b0;
      w_wb_rd_nx       = r_wb_rd;
      w_wb_data_nx     = r_wb_data;
      w_fault_nx       = 1'b0;
      w_fault_addr_nx  = r_fault_addr;
      w_fault_count_nx = r_fault_count;

      unique case (r_state)
         ST_IDLE: begin
            if (bus.req_valid) begin
               w_req_nx.is_store = bus.req_is_store;
               w_req_nx.ea       = w_ea;
               w_req_nx.wdata    = bus.req_wdata;
               w_req_nx.rd       = bus.req_rd;
               if (w_oor) begin
                  w_state_nx      = ST_FLT;
                  w_fault_nx      = 1'b1;
                  w_fault_addr_nx = w_ea;
                  if (r_fault_count != CNT_MAX) begin
                     w_fault_count_nx = r_fault_count + CNT_W'(1);
                  end
               end else begin
                  w_state_nx     = ST_EXEC;
                  w_mem_read_nx  = ~bus.req_is_store;
                  w_mem_write_nx = bus.req_is_store;
                  w_mem_addr_nx  = w_ea;
                  w_mem_wdata_nx = bus.req_is_store ? bus.req_wdata : '0;
               end
            end
         end
         ST_EXEC: begin
            // RAM read data is combinational on mem_addr; capture it as the EXEC cycle ends.
            if (r_req.is_store) begin
               w_state_nx = ST_IDLE;
            end else begin
               w_state_nx    = ST_RESP;
               w_wb_valid_nx = 1'b1;
               w_wb_rd_nx    = r_req.rd;
               w_wb_data_nx  = bus.mem_rdata;
            end
         end
         ST_RESP: w_state_nx = ST_IDLE;
         ST_FLT:  w_state_nx = ST_IDLE;
         default: w_state_nx = ST_IDLE;
      endcase

      w_req_ready_nx = (w_state_nx == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_req         <= '0;
         r_req_ready   <= 1'b1;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_wb_valid    <= 1'b0;
         r_wb_rd       <= '0;
         r_wb_data     <= '0;
         r_fault       <= 1'b0;
         r_fault_addr  <= '0;
         r_fault_count <= '0;
      end else begin
         r_state       <= w_state_nx;
         r_req         <= w_req_nx;
         r_req_ready   <= w_req_ready_nx;
         r_mem_read    <= w_mem_read_nx;
         r_mem_write   <= w_mem_write_nx;
         r_mem_addr    <= w_mem_addr_nx;
         r_mem_wdata   <= w_mem_wdata_nx;
         r_wb_valid    <= w_wb_valid_nx;
         r_wb_rd       <= w_wb_rd_nx;
         r_wb_data     <= w_wb_data_nx;
         r_fault       <= w_fault_nx;
         r_fault_addr  <= w_fault_addr_nx;
         r_fault_count <= w_fault_count_nx;
      end
   end

   assign bus.req_ready   = r_req_ready;
   assign bus.mem_read    = r_mem_read;
   assign bus.mem_write   = r_mem_write;
   assign bus.mem_addr    = r_mem_addr;
   assign bus.mem_wdata   = r_mem_wdata;
   assign bus.wb_valid    = r_wb_valid;
   assign bus.wb_rd       = r_wb_rd;
   assign bus.wb_data     = r_wb_data;
   assign bus.fault       = r_fault;
   assign bus.fault_addr  = r_fault_addr;
   assign bus.fault_count = r_fault_count;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a transaction-level model predicts RAM
// strobes, writebacks and faults with their cycle; a monitor checks them.
module tb_load_store_unit;
   import lsu_pkg::*;

   typedef struct {
      int        cyc;
      logic [7:0] a;
      logic [7:0] d;
      logic [1:0] rd;
   } ev_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_cmp;
   int   n_bad;

   load_store_unit_if bus ();

   load_store_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Environment RAM: combinational read, write on the rising edge.
   logic [7:0] ram [16] = '{8'h3C, 8'h91, 8'h07, 8'hE4, 8'h5A, 8'h12, 8'hC8, 8'h6F,
                            8'hB3, 8'h20, 8'h44, 8'hD9, 8'h8E, 8'h71, 8'h0B, 8'hF6};
   assign bus.mem_rdata = ram[bus.mem_addr[3:0]];
   always @(posedge clk) if (bus.mem_write) ram[bus.mem_addr[3:0]] <= bus.mem_wdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // Reference model state
   logic [7:0] model_mem [16];
   int         mcount;
   int         free_at;
   logic [7:0] last_fault;
   ev_t        wq[$];
   ev_t        rq[$];
   ev_t        wbq[$];
   ev_t        fq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"},   64'(bus.req_ready), 64'd1);
      chk({tag, "_mem_read"},    64'(bus.mem_read), 64'd0);
      chk({tag, "_mem_write"},   64'(bus.mem_write), 64'd0);
      chk({tag, "_mem_addr"},    64'(bus.mem_addr), 64'd0);
      chk({tag, "_mem_wdata"},   64'(bus.mem_wdata), 64'd0);
      chk({tag, "_wb_valid"},    64'(bus.wb_valid), 64'd0);
      chk({tag, "_wb_rd"},       64'(bus.wb_rd), 64'd0);
      chk({tag, "_wb_data"},     64'(bus.wb_data), 64'd0);
      chk({tag, "_fault"},       64'(bus.fault), 64'd0);
      chk({tag, "_fault_addr"},  64'(bus.fault_addr), 64'd0);
      chk({tag, "_fault_count"}, 64'(bus.fault_count), 64'd0);
   endtask

   // Transaction-level prediction for a request accepted at the coming edge.
   task automatic model_issue(input bit st, input logic [7:0] b, input logic [7:0] o,
                              input logic [7:0] wd, input logic [1:0] rd);
      int         hs;
      logic [7:0] ea;
      ev_t        e;
      hs = cyc + 1;
      ea = b + o;
      if (ea > 8'd15) begin
         mcount     = (mcount >= 255) ? 255 : mcount + 1;
         last_fault = ea;
         e = '{cyc: hs, a: ea, d: 8'(mcount), rd: 2'd0};
         fq.push_back(e);
         free_at = hs + 1;
      end else if (st) begin
         e = '{cyc: hs, a: ea, d: wd, rd: 2'd0};
         wq.push_back(e);
         model_mem[ea[3:0]] = wd;
         free_at = hs + 1;
      end else begin
         e = '{cyc: hs, a: ea, d: 8'd0, rd: 2'd0};
         rq.push_back(e);
         e = '{cyc: hs + 1, a: ea, d: model_mem[ea[3:0]], rd: rd};
         wbq.push_back(e);
         free_at = hs + 2;
      end
   endtask

   // One cycle of stimulus, entered and left on a falling edge.
   task automatic step(input bit v, input bit st, input logic [7:0] b, input logic [7:0] o,
                       input logic [7:0] wd, input logic [1:0] rd, output bit hs);
      bit exp_rdy;
      bus.req_valid    = v;
      bus.req_is_store = st;
      bus.req_base     = b;
      bus.req_offset   = o;
      bus.req_wdata    = wd;
      bus.req_rd       = rd;
      exp_rdy = (cyc >= free_at);
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      hs = v && exp_rdy;
      if (hs) model_issue(st, b, o, wd, rd);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bit hs;
      for (int i = 0; i < n; i++)
         step(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), hs);
   endtask

   task automatic issue(input bit st, input logic [7:0] b, input logic [7:0] o,
                        input logic [7:0] wd, input logic [1:0] rd);
      bit hs;
      hs = 1'b0;
      for (int k = 0; k < 20 && !hs; k++) step(1'b1, st, b, o, wd, rd, hs);
      chk("issue_accepted", 64'(hs), 64'd1);
   endtask

   // Monitor: pops predicted events whenever the DUT presents them.
   always @(negedge clk) begin
      ev_t e;
      if (rst_n) begin
         chk("rw_exclusive", 64'(bus.mem_read & bus.mem_write), 64'd0);
         while (wq.size() != 0 && wq[0].cyc < cyc) begin
            chk("write_missed", 64'(wq[0].cyc), 64'(cyc));
            void'(wq.pop_front());
         end
         while (rq.size() != 0 && rq[0].cyc < cyc) begin
            chk("read_missed", 64'(rq[0].cyc), 64'(cyc));
            void'(rq.pop_front());
         end
         while (wbq.size() != 0 && wbq[0].cyc < cyc) begin
            chk("wb_missed", 64'(wbq[0].cyc), 64'(cyc));
            void'(wbq.pop_front());
         end
         while (fq.size() != 0 && fq[0].cyc < cyc) begin
            chk("fault_missed", 64'(fq[0].cyc), 64'(cyc));
            void'(fq.pop_front());
         end
         if (bus.mem_write) begin
            chk("write_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
               e = wq.pop_front();
               chk("store", {16'd0, 32'(cyc), bus.mem_addr, bus.mem_wdata},
                            {16'd0, 32'(e.cyc), e.a, e.d});
            end
         end
         if (bus.mem_read) begin
            chk("read_expected", 64'(rq.size() != 0), 64'd1);
            if (rq.size() != 0) begin
               e = rq.pop_front();
               chk("load_exec", {24'd0, 32'(cyc), bus.mem_addr}, {24'd0, 32'(e.cyc), e.a});
            end
         end
         if (!bus.mem_read && !bus.mem_write)
            chk("bus_quiet", {48'd0, bus.mem_addr, bus.mem_wdata}, 64'd0);
         if (bus.wb_valid) begin
            chk("wb_expected", 64'(wbq.size() != 0), 64'd1);
            if (wbq.size() != 0) begin
               e = wbq.pop_front();
               chk("writeback", {16'd0, 32'(cyc), 6'd0, bus.wb_rd, bus.wb_data},
                                {16'd0, 32'(e.cyc), 6'd0, e.rd, e.d});
            end
         end
         if (bus.fault) begin
            chk("fault_expected", 64'(fq.size() != 0), 64'd1);
            if (fq.size() != 0) begin
               e = fq.pop_front();
               chk("fault", {16'd0, 32'(cyc), bus.fault_addr, bus.fault_count},
                            {16'd0, 32'(e.cyc), e.a, e.d});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit         hs;
      bit         v;
      bit         st;
      logic [7:0] b;
      logic [7:0] o;
      logic [7:0] a;
      logic [7:0] d;
      cyc     = 0;
      n_cmp   = 0;
      n_bad   = 0;
      mcount  = 0;
      free_at = 0;
      last_fault = 8'd0;
      for (int i = 0; i < 16; i++) model_mem[i] = ram[i];
      bus.req_valid    = 1'b0;
      bus.req_is_store = 1'b0;
      bus.req_base     = 8'd0;
      bus.req_offset   = 8'd0;
      bus.req_wdata    = 8'd0;
      bus.req_rd       = 2'd0;

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2 chk_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // Directed: store then load of same address, fault, address wrap
      issue(1'b1, 8'h03, 8'h02, 8'hA5, 2'd1);
      issue(1'b0, 8'h05, 8'h00, 8'h00, 2'd2);
      issue(1'b0, 8'h10, 8'h01, 8'h00, 2'd3);
      issue(1'b0, 8'hF8, 8'h0A, 8'h00, 2'd1);
      idle(4);
      chk("fault_addr_0x11", 64'(bus.fault_addr), 64'h11);
      chk("fault_count_1", 64'(bus.fault_count), 64'd1);

      // Random traffic; valid stays high most cycles with changing payload
      for (int i = 0; i < 600; i++) begin
         v  = ($urandom_range(0, 7) != 0);
         st = 1'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         o  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
         step(v, st, b, o, 8'($urandom), 2'($urandom), hs);
      end
      idle(4);

      // Fault counter saturation
      for (int i = 0; i < 257; i++)
         issue(1'($urandom), 8'($urandom_range(16, 255)), 8'd0, 8'($urandom), 2'($urandom));
      idle(4);
      chk("fault_count_sat", 64'(bus.fault_count), 64'd255);
      chk("fault_addr_held", 64'(bus.fault_addr), 64'(last_fault));
      issue(1'b0, 8'hFF, 8'h20, 8'h00, 2'd0);
      idle(3);
      chk("fault_count_stays", 64'(bus.fault_count), 64'd255);

      // Asynchronous reset during a store's EXEC cycle
      a = 8'($urandom_range(0, 15));
      d = ~model_mem[a[3:0]];
      bus.req_valid    = 1'b1;
      bus.req_is_store = 1'b1;
      bus.req_base     = a;
      bus.req_offset   = 8'd0;
      bus.req_wdata    = d;
      bus.req_rd       = 2'd0;
      chk("rst_store_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      chk("rst_store_exec", {55'd0, bus.mem_write, bus.mem_addr}, {55'd0, 1'b1, a});
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs("async_reset");
      mcount  = 0;
      free_at = 0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_no_commit", 64'(ram[a[3:0]]), 64'(model_mem[a[3:0]]));
      issue(1'b0, a, 8'h00, 8'h00, 2'd3);
      idle(4);

      chk("queues_drained", 64'(wq.size() + rq.size() + wbq.size() + fq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the tiny 8-bit core, directly upstream of the 16-byte data RAM. It accepts one load/store request at a time from the execute stage over a valid/ready handshake. It computes the effective address as base + offset, range-checks it against the implemented RAM, and drives the RAM's read/write strobes. Load data returns to the register-file writeback port as a one-cycle pulse.

## Interface
- ADDR_W, 8, address width, also base/offset width
- DATA_W, 8, data width
- RAM_AW, 4, implemented RAM address bits; addresses ≥ 2**RAM_AW fault
- RD_W, 2, destination register index width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_is_store  in  1  1 = store, 0 = load
- req_base  in  ADDR_W  base register value
- req_offset  in  ADDR_W  immediate offset, unsigned, added modulo 2**ADDR_W
- req_wdata  in  DATA_W  store data
- req_rd  in  RD_W  load destination register
- mem_read  out  1  RAM read strobe
- mem_write  out  1  RAM write strobe
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM combinational read data
- wb_valid  out  1  one-cycle load writeback pulse
- wb_rd  out  RD_W  writeback register index
- wb_data  out  DATA_W  writeback data
- fault  out  1  one-cycle out-of-range pulse
- fault_addr  out  ADDR_W  last faulting effective address, held
- fault_count  out  8  saturating fault counter

## Operation
- FSM states: IDLE, EXEC, RESP, FLT.
- IDLE: req_ready=1. On req_valid, latch is_store, wdata, rd and ea = (base+offset) mod 256.
  - If ea[7:RAM_AW] != 0, go to FLT.
  - Otherwise go to EXEC.
- EXEC: mem_addr=ea. Store: mem_write=1, mem_wdata=latched data, then IDLE. Load: mem_read=1, capture mem_rdata into wb_data at the cycle end, then RESP.
- RESP: wb_valid=1, wb_rd=latched rd, then IDLE.
- FLT: fault=1, fault_addr=ea, fault_count increments and saturates at 255. No RAM strobe. Then IDLE.
- mem_read and mem_write are never high together. Both are low outside EXEC. mem_addr and mem_wdata are 0 outside EXEC.
- wb_data holds its last value between pulses. wb_valid is the only qualifier.
- req_* inputs are ignored when req_ready=0. No request queuing.

## Timing
- Reset values: state IDLE; req_ready=1; mem_read, mem_write, wb_valid and fault = 0; mem_addr, mem_wdata, wb_rd, wb_data, fault_addr and fault_count = 0.
- Handshake at edge N (valid & ready). EXEC or FLT is in cycle N+1. A load's wb_valid is in cycle N+2.
- Store occupancy is 2 cycles. Load is 3. Fault is 2.
- Store then load to the same address: the RAM write commits at the end of store-EXEC. The load's EXEC is at least 1 cycle later, so it returns the new data.
- Address wrap: base=0xF8, offset=0x0A gives ea=0x02, which is in range and not a fault.
- Async reset mid-EXEC drops mem_write immediately. If rst_n falls before the rising edge, that store does not commit. In-flight load writeback is discarded.
- fault_count at 255 stays at 255 on further faults. fault still pulses.

## Structure
- lsu_pkg holds the FSM state enum (lsu_state_t) and the EA_FAULT_MASK derived from ADDR_W/RAM_AW.
- One combinational sub-module, lsu_addr_gen: base + offset → ea, plus an out_of_range flag. Everything else lives in load_store_unit.

## Test plan
- Reset with all outputs checked at 0 and req_ready=1. Store base=0x03, offset=0x02, data=0xA5 → mem_write high one cycle at addr 0x05 with wdata 0xA5. No wb_valid.
- Load base=0x05, offset=0 right after that store → mem_read in N+1; wb_valid in N+2 with wb_data=0xA5 and wb_rd=req_rd.
- Load base=0x10, offset=0x01 → fault pulse, fault_addr=0x11, fault_count=1, no mem_read or mem_write.
- Wrap: base=0xF8, offset=0x0A load → mem_addr=0x02, no fault.
- req_valid held high continuously with varying data → only handshake-cycle values are used, and req_ready is low in EXEC, RESP and FLT.
- 257 consecutive faults → fault_count=255. Reset asserted mid-store-EXEC → no RAM write, and all outputs return to reset values asynchronously.
